// File: rtl/rtc_pkg.sv
// Shared RTC definitions: BCD time layout, field offsets and digit limits.
// Imported by the RTC clock, alarm and timer units.
package rtc_pkg;

  localparam int SEC_LO     = 0;
  localparam int MIN_LO     = 8;
  localparam int HR_LO      = 16;
  localparam int RUN_BIT    = 24;
  localparam int RELOAD_BIT = 25;

  localparam logic [3:0] ONES_MAX    = 4'd9;
  localparam logic [3:0] TENS_MAX    = 4'd5;
  localparam logic [3:0] HR_TENS_MAX = 4'd9;

  // Bits 7 and 15 are tens-digit MSBs that are never set
  localparam logic [23:0] BCD_MASK    = 24'hFF7F7F;
  localparam logic [23:0] BCD_ONE_SEC = 24'h000001;

  typedef logic [23:0] bcd_time_t;

  typedef struct packed {
    logic reload;
    logic alarm;
    logic running;
  } rtc_timer_status_t;

  // Returns {borrow_out, digit}
  function automatic logic [4:0] bcd_dec_digit(
    input logic [3:0] d,
    input logic [3:0] mx,
    input logic       bin
  );
    logic [4:0] r;
    r = {1'b0, d};
    if (bin) begin
      if (d == 4'd0) r = {1'b1, mx};
      else           r = {1'b0, d - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/rtcmtimer_if.sv
// Register bus between the RTC decode and the multi-channel timer.
// Write strobe, channel select, data/valids in; selected channel status out.
interface rtcmtimer_if #(
  parameter int LGNT = 2
);
  logic            i_wr;
  logic [LGNT-1:0] i_sel;
  logic [25:0]     i_data;
  logic [2:0]      i_valid;
  logic [31:0]     o_data;

  modport master (
    output i_wr, i_sel, i_data, i_valid,
    input  o_data
  );

  modport slave (
    input  i_wr, i_sel, i_data, i_valid,
    output o_data
  );
endinterface

// File: rtl/rtc_bcd_decrement.sv
// Registered 24-bit HH:MM:SS BCD decrement with last-tick and zero flags.
// o_last: input was 00:00:01; o_zero: input was 00:00:00 (no valid result).
module rtc_bcd_decrement
  import rtc_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_reset_n,
  input  logic      i_ce,
  input  bcd_time_t i_time,
  output bcd_time_t o_time,
  output logic      o_last,
  output logic      o_zero
);

  logic [4:0] w_d0, w_d1, w_d2, w_d3, w_d4, w_d5;
  bcd_time_t  w_next;

  assign w_d0 = bcd_dec_digit(i_time[SEC_LO +: 4], ONES_MAX, 1'b1);
  assign w_d1 = bcd_dec_digit(i_time[SEC_LO+4 +: 4], TENS_MAX, w_d0[4]);
  assign w_d2 = bcd_dec_digit(i_time[MIN_LO +: 4], ONES_MAX, w_d1[4]);
  assign w_d3 = bcd_dec_digit(i_time[MIN_LO+4 +: 4], TENS_MAX, w_d2[4]);
  assign w_d4 = bcd_dec_digit(i_time[HR_LO +: 4], ONES_MAX, w_d3[4]);
  assign w_d5 = bcd_dec_digit(i_time[HR_LO+4 +: 4], HR_TENS_MAX, w_d4[4]);

  assign w_next = {w_d5[3:0], w_d4[3:0], w_d3[3:0],
                   w_d2[3:0], w_d1[3:0], w_d0[3:0]};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_time <= '0;
      o_last <= 1'b0;
      o_zero <= 1'b0;
    end else if (i_ce) begin
      o_time <= w_next;
      o_last <= (i_time == BCD_ONE_SEC);
      o_zero <= (i_time == '0);
    end
  end

endmodule

// File: rtl/rtcmtimer.sv
// NTIMERS-channel BCD countdown timer sharing one decrement pipeline.
// Periodic auto-reload is built only with RTCMTIMER_RELOAD_EN defined.
module rtcmtimer
  import rtc_pkg::*;
#(
  parameter int NTIMERS = 4,
  parameter int LGNT    = (NTIMERS > 1) ? $clog2(NTIMERS) : 1,
  parameter int LGSUBCK = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_sub_ck,
  rtcmtimer_if.slave         bus,
  output logic [NTIMERS-1:0] o_int,
  output logic               o_interrupt
);

  bcd_time_t          r_count [NTIMERS];
  logic [LGSUBCK-1:0] r_sub   [NTIMERS];
  logic [NTIMERS-1:0] r_run;
  logic [NTIMERS-1:0] r_alarm;
  logic [NTIMERS-1:0] r_pend;
  logic [NTIMERS-1:0] r_int;
  logic [NTIMERS-1:0] w_rld;
  bcd_time_t          w_rval;

  logic [LGNT-1:0] r_rr;
  logic [LGNT-1:0] r_s1_ch;
  logic            r_s1_vld;
  logic [LGNT-1:0] w_pick;
  logic            w_pick_vld;
  logic [LGNT:0]   w_jj;
  logic            w_issue;
  logic            w_wb;

  logic      w_wr;
  bcd_time_t w_wdata;
  logic      w_wrun;
  logic      w_load;

  bcd_time_t         w_dec_time;
  logic              w_dec_last;
  logic              w_dec_zero;
  rtc_timer_status_t w_st;
  logic [31:0]       r_data;

  assign w_wr    = bus.i_wr &&
                   ({1'b0, bus.i_sel} < (LGNT+1)'(NTIMERS));
  assign w_wdata = bus.i_data[23:0] & BCD_MASK;
  assign w_wrun  = bus.i_data[RUN_BIT];
  assign w_load  = (bus.i_valid == 3'b111) && (w_wdata != '0);

  // Round-robin: search starts just after the last served channel
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_jj       = '0;
    for (int k = NTIMERS - 1; k >= 0; k--) begin
      w_jj = {1'b0, r_rr} + (LGNT+1)'(k + 1);
      if (w_jj >= (LGNT+1)'(NTIMERS))
        w_jj = w_jj - (LGNT+1)'(NTIMERS);
      if (r_pend[w_jj[LGNT-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_jj[LGNT-1:0];
      end
    end
  end

  assign w_issue = w_pick_vld &&
                   !(w_wr && bus.i_sel == w_pick);
  assign w_wb    = r_s1_vld && !w_dec_zero &&
                   !(w_wr && bus.i_sel == r_s1_ch);

  rtc_bcd_decrement u_dec (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_ce      (w_issue),
    .i_time    (r_count[w_pick]),
    .o_time    (w_dec_time),
    .o_last    (w_dec_last),
    .o_zero    (w_dec_zero)
  );

`ifdef RTCMTIMER_RELOAD_EN
  logic [NTIMERS-1:0] r_rld;
  bcd_time_t          r_rval [NTIMERS];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rld <= '0;
      for (int i = 0; i < NTIMERS; i++) r_rval[i] <= '0;
    end else if (w_wr) begin
      r_rld[bus.i_sel] <= bus.i_data[RELOAD_BIT];
      if (!r_run[bus.i_sel] && w_load)
        r_rval[bus.i_sel] <= w_wdata;
    end
  end

  assign w_rld  = r_rld;
  assign w_rval = r_rval[r_s1_ch];
`else
  logic w_unused_rld;
  assign w_unused_rld = bus.i_data[RELOAD_BIT];
  assign w_rld  = '0;
  assign w_rval = '0;
`endif

  always_comb begin
    w_st         = '0;
    w_st.reload  = w_rld[bus.i_sel];
    w_st.alarm   = r_alarm[bus.i_sel];
    w_st.running = r_run[bus.i_sel];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NTIMERS; i++) begin
        r_count[i] <= '0;
        r_sub[i]   <= '0;
      end
      r_run    <= '0;
      r_alarm  <= '0;
      r_pend   <= '0;
      r_int    <= '0;
      r_rr     <= '0;
      r_s1_ch  <= '0;
      r_s1_vld <= 1'b0;
      r_data   <= '0;
    end else begin
      r_int    <= '0;
      r_s1_vld <= w_issue;
      r_s1_ch  <= w_pick;
      if (w_issue) begin
        r_pend[w_pick] <= 1'b0;
        r_rr           <= w_pick;
      end
      for (int i = 0; i < NTIMERS; i++) begin
        if (r_run[i] && i_sub_ck) begin
          r_sub[i] <= r_sub[i] + 1'b1;
          if (&r_sub[i]) r_pend[i] <= 1'b1;
        end
      end
      if (w_wb) begin
        if (w_dec_last) begin
          r_count[r_s1_ch] <= w_rld[r_s1_ch] ? w_rval : '0;
          r_alarm[r_s1_ch] <= 1'b1;
          r_int[r_s1_ch]   <= 1'b1;
          if (!w_rld[r_s1_ch]) r_run[r_s1_ch] <= 1'b0;
        end else begin
          r_count[r_s1_ch] <= w_dec_time;
        end
      end
      // A write overrides any same-cycle tick or writeback
      if (w_wr) begin
        if (r_run[bus.i_sel]) begin
          r_run[bus.i_sel] <= w_wrun;
          if (!w_wrun) r_pend[bus.i_sel] <= 1'b0;
        end else begin
          r_alarm[bus.i_sel] <= 1'b0;
          if (w_load) begin
            r_count[bus.i_sel] <= w_wdata;
            r_sub[bus.i_sel]   <= '0;
            r_pend[bus.i_sel]  <= 1'b0;
            r_run[bus.i_sel]   <= w_wrun;
          end else if (w_wdata == '0 &&
                       r_count[bus.i_sel] != '0) begin
            r_run[bus.i_sel] <= w_wrun;
          end
        end
      end
      r_data <= {5'h0, w_st, r_count[bus.i_sel]};
    end
  end

  assign bus.o_data  = r_data;
  assign o_int       = r_int;
  assign o_interrupt = |r_int;

endmodule
